// File: rtl/seq_multiplier.sv
// seq_multiplier: WIDTH-cycle shift-add multiplier, unsigned or two's-complement per operation
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a multiply (accepted in IDLE or DONE)
//   signed_mode       1 = two's-complement operands/product, sampled with start
//   op_a, op_b        multiplicand / multiplier, sampled with start
//   busy              high while iterating
//   done              one-cycle pulse when product is updated
//   product           2*WIDTH-bit result, held until the next completion
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               accept, last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;

    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH-1));
    assign abs_a  = (signed_mode && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b  = (signed_mode && op_b[WIDTH-1]) ? -op_b : op_b;
    // Upper half of acc holds the partial sum; lower half still holds unconsumed multiplier bits.
    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
    assign acc_step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? RUN : (state_q == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        busy    = (state_q == RUN);
        done    = (state_q == DONE);
        product = product_q;
    end

    always_comb begin
        mag_a_d   = accept ? abs_a : mag_a_q;
        neg_d     = accept ? (signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1])) : neg_q;
        acc_d     = accept ? {{WIDTH{1'b0}}, abs_b} : (state_q == RUN) ? acc_step : acc_q;
        cnt_d     = accept ? '0 : (state_q == RUN) ? cnt_q + CW'(1) : cnt_q;
        product_d = last ? (neg_q ? -acc_step : acc_step) : product_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mag_a_q   <= mag_a_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
endmodule
